// File: rtl/alu_issue_stage_if.sv
// Handshake and operand bus between decode, the ALU issue stage and the ALU.
// The slave modport is the issue stage's view; the master modport drives it.
interface alu_issue_stage_if #(
  parameter int XLEN = 32
);
  logic            IN_VALID;
  logic            IN_READY;
  logic [31:0]     INSTR;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] RS1_DATA;
  logic [XLEN-1:0] RS2_DATA;
  logic            FLUSH;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic [XLEN-1:0] DATA1;
  logic [XLEN-1:0] DATA2;
  logic [2:0]      SELECT;
  logic            ROTATE;
  logic [4:0]      RD_ADDR;
  logic            RD_WE;
  logic            ILLEGAL;

  modport slave (
    input  IN_VALID, INSTR, PC, RS1_DATA, RS2_DATA, FLUSH, OUT_READY,
    output IN_READY, OUT_VALID, DATA1, DATA2, SELECT, ROTATE, RD_ADDR, RD_WE, ILLEGAL
  );

  modport master (
    output IN_VALID, INSTR, PC, RS1_DATA, RS2_DATA, FLUSH, OUT_READY,
    input  IN_READY, OUT_VALID, DATA1, DATA2, SELECT, ROTATE, RD_ADDR, RD_WE, ILLEGAL
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Decodes RV32I register/immediate ALU instructions into ALU operands and
// issues them through an output register backed by a one-entry skid buffer.
module alu_issue_stage #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic           CLK,
  input  logic           RESET_N,
  alu_issue_stage_if.slave bus
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [2:0]      sel;
    logic            rotate;
    logic [4:0]      rd_addr;
    logic            rd_we;
    logic            illegal;
  } issue_t;

  function automatic logic [2:0] sel_of(input logic [2:0] f3);
    case (f3)
      3'b000:  sel_of = 3'd1;
      3'b001:  sel_of = 3'd7;
      3'b100:  sel_of = 3'd4;
      3'b101:  sel_of = 3'd6;
      3'b110:  sel_of = 3'd3;
      default: sel_of = 3'd2;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] shamt_of(input logic [XLEN-1:0] src);
    shamt_of = {{(XLEN-SHAMT_W){1'b0}}, src[SHAMT_W-1:0]};
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic            is_shift;
  logic            slt_form;
  issue_t          dec;
  issue_t          o_q;
  issue_t          s_q;
  logic            o_valid;
  logic            s_valid;
  logic            accept;
  logic            consume;
  logic            unused_rs1_field;

  assign opcode           = bus.INSTR[6:0];
  assign f3               = bus.INSTR[14:12];
  assign f7               = bus.INSTR[31:25];
  assign imm_i            = {{(XLEN-12){bus.INSTR[31]}}, bus.INSTR[31:20]};
  assign imm_u            = {bus.INSTR[31:12], 12'b0};
  assign is_shift         = (f3 == 3'b001) || (f3 == 3'b101);
  assign slt_form         = (f3 == 3'b010) || (f3 == 3'b011);
  assign unused_rs1_field = ^bus.INSTR[19:15];

  // NOTE: every field gets a default before the case so no path leaves a latch.
  always_comb begin
    dec = '0;
    unique case (opcode)
      OPC_OP: begin
        if (slt_form || !(f7 == 7'b0000000 || f7 == 7'b0100000)) begin
          dec.illegal = 1'b1;
        end else begin
          dec.data1 = bus.RS1_DATA;
          dec.sel   = sel_of(f3);
          if (is_shift) begin
            dec.data2  = shamt_of(bus.RS2_DATA);
            dec.rotate = (f3 == 3'b101) && f7[5];
          end else if (f3 == 3'b000 && f7[5]) begin
            dec.data2 = ~bus.RS2_DATA + 1'b1;
          end else begin
            dec.data2 = bus.RS2_DATA;
          end
        end
      end
      OPC_IMM: begin
        // Immediate shifts allow only funct7 0000000, plus 0100000 for SRAI.
        if (slt_form
            || (f3 == 3'b001 && f7 != 7'b0000000)
            || (f3 == 3'b101 && !(f7 == 7'b0000000 || f7 == 7'b0100000))) begin
          dec.illegal = 1'b1;
        end else begin
          dec.data1 = bus.RS1_DATA;
          dec.sel   = sel_of(f3);
          if (is_shift) begin
            dec.data2  = shamt_of(imm_i);
            dec.rotate = (f3 == 3'b101) && bus.INSTR[30];
          end else begin
            dec.data2 = imm_i;
          end
        end
      end
      OPC_LUI: begin
        dec.sel   = 3'd0;
        dec.data2 = imm_u;
      end
      OPC_AUIPC: begin
        dec.sel   = 3'd1;
        dec.data1 = bus.PC;
        dec.data2 = imm_u;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.rd_addr = bus.INSTR[11:7];
    dec.rd_we   = !dec.illegal && (bus.INSTR[11:7] != 5'd0);
  end

  assign bus.IN_READY = !s_valid;
  assign accept       = bus.IN_VALID && !s_valid;
  assign consume      = o_valid && bus.OUT_READY;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      o_valid <= 1'b0;
      s_valid <= 1'b0;
      o_q     <= '0;
    end else if (bus.FLUSH) begin
      o_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (s_valid) begin
      if (consume) begin
        o_q     <= s_q;
        s_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!o_valid || consume) begin
        o_q     <= dec;
        o_valid <= 1'b1;
      end else begin
        s_valid <= 1'b1;
      end
    end else if (consume) begin
      o_valid <= 1'b0;
    end
  end

  // NOTE: the skid payload has no reset; it is only ever read while s_valid,
  // and s_valid is reset.
  always_ff @(posedge CLK) begin
    if (accept && o_valid && !consume && !bus.FLUSH) begin
      s_q <= dec;
    end
  end

  assign bus.OUT_VALID = o_valid;
  assign bus.DATA1     = o_q.data1;
  assign bus.DATA2     = o_q.data2;
  assign bus.SELECT    = o_q.sel;
  assign bus.ROTATE    = o_q.rotate;
  assign bus.RD_ADDR   = o_q.rd_addr;
  assign bus.RD_WE     = o_q.rd_we;
  assign bus.ILLEGAL   = o_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed checks of decode, skid buffering, flush and reset of alu_issue_stage.
module tb_alu_issue_stage;

  logic CLK;
  logic RESET_N;
  int   passed;
  int   total;

  alu_issue_stage_if #(.XLEN(32)) bus ();

  alu_issue_stage #(.XLEN(32), .SHAMT_W(5)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] IMM = 7'b0010011;

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
    r_type = {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
    i_type = {imm, rs1, f3, rd, opc};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
    bus.IN_VALID = 1'b1;
    bus.INSTR    = instr;
    bus.RS1_DATA = rs1;
    bus.RS2_DATA = rs2;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(bus.OUT_VALID), 32'd0);
    check({tag, "_in_ready"},  32'(bus.IN_READY),  32'd1);
    check({tag, "_data1"},     bus.DATA1,          32'd0);
    check({tag, "_data2"},     bus.DATA2,          32'd0);
    check({tag, "_select"},    32'(bus.SELECT),    32'd0);
    check({tag, "_rotate"},    32'(bus.ROTATE),    32'd0);
    check({tag, "_rd_addr"},   32'(bus.RD_ADDR),   32'd0);
    check({tag, "_rd_we"},     32'(bus.RD_WE),     32'd0);
    check({tag, "_illegal"},   32'(bus.ILLEGAL),   32'd0);
  endtask

  initial begin
    passed        = 0;
    total         = 0;
    RESET_N       = 1'b0;
    bus.IN_VALID  = 1'b0;
    bus.INSTR     = 32'd0;
    bus.PC        = 32'h0000_1000;
    bus.RS1_DATA  = 32'd0;
    bus.RS2_DATA  = 32'd0;
    bus.FLUSH     = 1'b0;
    bus.OUT_READY = 1'b1;
    #2;
    check_zero_outputs("reset");
    tick();
    RESET_N = 1'b1;
    tick();

    // SUB x3,x1,x2 : 5 - 7
    offer(r_type(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, OP), 32'd5, 32'd7);
    tick();
    check("sub_valid", 32'(bus.OUT_VALID), 32'd1);
    check("sub_select", 32'(bus.SELECT), 32'd1);
    check("sub_data1", bus.DATA1, 32'd5);
    check("sub_data2", bus.DATA2, 32'hFFFF_FFF9);
    check("sub_rd_addr", 32'(bus.RD_ADDR), 32'd3);
    check("sub_rd_we", 32'(bus.RD_WE), 32'd1);

    // SRAI x4,x4,31
    offer(i_type(12'h41F, 5'd4, 3'b101, 5'd4, IMM), 32'h8000_0000, 32'd0);
    tick();
    check("srai_select", 32'(bus.SELECT), 32'd6);
    check("srai_rotate", 32'(bus.ROTATE), 32'd1);
    check("srai_data1", bus.DATA1, 32'h8000_0000);
    check("srai_data2", bus.DATA2, 32'd31);

    // SRA x5,x4,x6 : shift source masked to low 5 bits
    offer(r_type(7'b0100000, 5'd6, 5'd4, 3'b101, 5'd5, OP), 32'h8000_0000, 32'hFFFF_FFE3);
    tick();
    check("sra_select", 32'(bus.SELECT), 32'd6);
    check("sra_rotate", 32'(bus.ROTATE), 32'd1);
    check("sra_data2", bus.DATA2, 32'd3);

    // SLLI x7,x1,4 and XORI x8,x1,-1
    offer(i_type(12'h004, 5'd1, 3'b001, 5'd7, IMM), 32'h1234_5678, 32'd0);
    tick();
    check("slli_select", 32'(bus.SELECT), 32'd7);
    check("slli_rotate", 32'(bus.ROTATE), 32'd0);
    check("slli_data2", bus.DATA2, 32'd4);
    offer(i_type(12'hFFF, 5'd1, 3'b100, 5'd8, IMM), 32'h1234_5678, 32'd0);
    tick();
    check("xori_select", 32'(bus.SELECT), 32'd4);
    check("xori_data2", bus.DATA2, 32'hFFFF_FFFF);

    // AUIPC x9,0xABCDE with PC=0x1000
    offer({20'hABCDE, 5'd9, 7'b0010111}, 32'd0, 32'd0);
    tick();
    check("auipc_select", 32'(bus.SELECT), 32'd1);
    check("auipc_data1", bus.DATA1, 32'h0000_1000);
    check("auipc_data2", bus.DATA2, 32'hABCD_E000);

    // SLT x5,x1,x2 is illegal but still issued
    offer(r_type(7'b0000000, 5'd2, 5'd1, 3'b010, 5'd5, OP), 32'd5, 32'd7);
    tick();
    check("slt_valid", 32'(bus.OUT_VALID), 32'd1);
    check("slt_illegal", 32'(bus.ILLEGAL), 32'd1);
    check("slt_rd_we", 32'(bus.RD_WE), 32'd0);
    check("slt_select", 32'(bus.SELECT), 32'd0);
    check("slt_data1", bus.DATA1, 32'd0);
    check("slt_data2", bus.DATA2, 32'd0);

    // LW x6,4(x1) : unsupported opcode
    offer(i_type(12'h004, 5'd1, 3'b010, 5'd6, 7'b0000011), 32'd5, 32'd7);
    tick();
    check("load_illegal", 32'(bus.ILLEGAL), 32'd1);
    check("load_rd_we", 32'(bus.RD_WE), 32'd0);
    check("load_data1", bus.DATA1, 32'd0);
    check("load_data2", bus.DATA2, 32'd0);

    // LUI x0 : legal, but no writeback
    offer({20'h12345, 5'd0, 7'b0110111}, 32'd5, 32'd7);
    tick();
    check("lui_illegal", 32'(bus.ILLEGAL), 32'd0);
    check("lui_rd_we", 32'(bus.RD_WE), 32'd0);
    check("lui_select", 32'(bus.SELECT), 32'd0);
    check("lui_data1", bus.DATA1, 32'd0);
    check("lui_data2", bus.DATA2, 32'h1234_5000);

    bus.IN_VALID = 1'b0;
    tick();
    check("drain_empty", 32'(bus.OUT_VALID), 32'd0);

    // Four ADDIs (imm = rd = 1..4) under 3 cycles of back-pressure
    bus.OUT_READY = 1'b0;
    offer(i_type(12'd1, 5'd1, 3'b000, 5'd1, IMM), 32'd100, 32'd0);
    tick();
    check("bp_in_ready_1", 32'(bus.IN_READY), 32'd1);
    offer(i_type(12'd2, 5'd1, 3'b000, 5'd2, IMM), 32'd100, 32'd0);
    tick();
    check("bp_in_ready_2", 32'(bus.IN_READY), 32'd0);
    check("bp_hold_a1", bus.DATA2, 32'd1);
    offer(i_type(12'd3, 5'd1, 3'b000, 5'd3, IMM), 32'd100, 32'd0);
    tick();
    check("bp_stable_data2", bus.DATA2, 32'd1);
    check("bp_stable_rd", 32'(bus.RD_ADDR), 32'd1);
    check("bp_still_full", 32'(bus.IN_READY), 32'd0);
    bus.OUT_READY = 1'b1;
    tick();
    check("drain_a2_data2", bus.DATA2, 32'd2);
    check("drain_a2_rd", 32'(bus.RD_ADDR), 32'd2);
    check("drain_a2_in_ready", 32'(bus.IN_READY), 32'd1);
    tick();
    check("drain_a3_data2", bus.DATA2, 32'd3);
    check("drain_a3_valid", 32'(bus.OUT_VALID), 32'd1);
    offer(i_type(12'd4, 5'd1, 3'b000, 5'd4, IMM), 32'd100, 32'd0);
    tick();
    check("drain_a4_data2", bus.DATA2, 32'd4);
    check("drain_a4_data1", bus.DATA1, 32'd100);
    bus.IN_VALID = 1'b0;
    tick();
    check("drain_done", 32'(bus.OUT_VALID), 32'd0);

    // Flush with O and S full and an instruction on offer
    bus.OUT_READY = 1'b0;
    offer(i_type(12'd10, 5'd1, 3'b000, 5'd10, IMM), 32'd0, 32'd0);
    tick();
    offer(i_type(12'd11, 5'd1, 3'b000, 5'd11, IMM), 32'd0, 32'd0);
    tick();
    check("flush_pre_full", 32'(bus.IN_READY), 32'd0);
    offer(i_type(12'd12, 5'd1, 3'b000, 5'd12, IMM), 32'd0, 32'd0);
    bus.FLUSH = 1'b1;
    tick();
    check("flush_out_valid", 32'(bus.OUT_VALID), 32'd0);
    check("flush_in_ready", 32'(bus.IN_READY), 32'd1);
    // Flush again while ready: the offered instruction is dropped
    tick();
    bus.FLUSH     = 1'b0;
    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b1;
    check("flush_drop_valid", 32'(bus.OUT_VALID), 32'd0);
    tick();
    check("flush_nothing_issued", 32'(bus.OUT_VALID), 32'd0);

    // Asynchronous reset with O and S full
    bus.OUT_READY = 1'b0;
    offer(i_type(12'd20, 5'd1, 3'b000, 5'd20, IMM), 32'd7, 32'd0);
    tick();
    offer(i_type(12'd21, 5'd1, 3'b000, 5'd21, IMM), 32'd7, 32'd0);
    tick();
    bus.IN_VALID = 1'b0;
    check("midreset_pre_valid", 32'(bus.OUT_VALID), 32'd1);
    check("midreset_pre_full", 32'(bus.IN_READY), 32'd0);
    #1;
    RESET_N = 1'b0;
    #1;
    check_zero_outputs("midreset");
    #1;
    RESET_N = 1'b1;
    bus.OUT_READY = 1'b1;
    offer(i_type(12'd9, 5'd1, 3'b000, 5'd9, IMM), 32'd7, 32'd0);
    tick();
    check("post_reset_valid", 32'(bus.OUT_VALID), 32'd1);
    check("post_reset_data2", bus.DATA2, 32'd9);
    check("post_reset_rd", 32'(bus.RD_ADDR), 32'd9);
    bus.IN_VALID = 1'b0;
    tick();
    check("post_reset_no_stale", 32'(bus.OUT_VALID), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode-to-execute pipeline stage that drives the operand and opcode inputs of the 32-bit integer ALU: DATA1, DATA2, SELECT and ROTATE.
- Accepts one RV32I register/immediate ALU instruction per cycle on a valid/ready handshake.
- Decodes it into the ALU's 3-bit SELECT encoding and registers the result.
- Holds results under back-pressure through a one-entry skid buffer, so throughput stays at one instruction per cycle without a combinational ready path.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- SHAMT_W, 5, number of shift-amount bits passed to the ALU.

Ports:
- CLK  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  upstream instruction valid.
- IN_READY  out  1  stage can accept an instruction.
- INSTR  in  32  instruction word.
- PC  in  32  address of INSTR.
- RS1_DATA  in  32  rs1 register value.
- RS2_DATA  in  32  rs2 register value.
- FLUSH  in  1  synchronous pipeline kill.
- OUT_VALID  out  1  ALU operands valid.
- OUT_READY  in  1  execute stage consumes this cycle.
- DATA1  out  32  ALU operand 1.
- DATA2  out  32  ALU operand 2.
- SELECT  out  3  ALU op: 0 pass DATA2, 1 add, 2 and, 3 or, 4 xor, 5 xnor, 6 shift right, 7 shift left.
- ROTATE  out  1  shift kind: 0 logical, 1 arithmetic.
- RD_ADDR  out  5  destination register.
- RD_WE  out  1  writeback enable.
- ILLEGAL  out  1  unsupported encoding flag.

Behaviour:
- Reset (RESET_N=0, asynchronous): the following are cleared immediately: OUT_VALID, DATA1, DATA2, SELECT, ROTATE, RD_ADDR, RD_WE, ILLEGAL and the skid-valid flag. IN_READY=1.
- Storage: output register (O) and skid register (S).
- IN_READY is driven only by the registered skid-valid flag: IN_READY = !S_valid.
- Transfer in occurs when IN_VALID & IN_READY. Transfer out occurs when OUT_VALID & OUT_READY.
- Latency: an instruction accepted at edge N is presented from edge N with OUT_VALID=1, one cycle after it was presented at the input.
- Edge rules:
  - O empty or consumed, S empty: the accepted instruction loads O.
  - O held (not consumed), S empty: the accepted instruction loads S.
  - O consumed, S full: S moves to O and S empties. Any new accept is impossible because IN_READY=0.
  - Ordering is strictly FIFO.
- Outputs are stable while OUT_VALID=1 and OUT_READY=0.
- FLUSH=1 at an edge: O and S are invalidated and IN_READY=1 next cycle. An instruction offered in the same cycle is dropped. FLUSH has priority over every transfer.
- Decode, by opcode INSTR[6:0]:
  - OP (0110011), funct3 / funct7[5]:
    - 000/0 ADD: SELECT=1, DATA2=RS2.
    - 000/1 SUB: SELECT=1, DATA2=~RS2+1 (two's complement, wrap modulo 2^32).
    - 001 SLL: SELECT=7, ROTATE=0.
    - 100 XOR: SELECT=4.
    - 101/0 SRL: SELECT=6, ROTATE=0.
    - 101/1 SRA: SELECT=6, ROTATE=1.
    - 110 OR: SELECT=3.
    - 111 AND: SELECT=2.
    - DATA1=RS1 for all OP encodings.
  - OP-IMM (0010011): same SELECT mapping with DATA2 = sign-extended I-immediate.
    - 000 has no SUB form.
    - Shifts use INSTR[30] for SRAI.
  - LUI (0110111): SELECT=0, DATA2={INSTR[31:12],12'b0}, DATA1=0.
  - AUIPC (0010111): SELECT=1, DATA1=PC, DATA2={INSTR[31:12],12'b0}.
- Shifts (all forms): DATA2 = zero-extended low SHAMT_W bits of the shift source (RS2 or immediate); upper 27 bits forced to 0.
- Illegal encodings: funct3 010/011 (SLT/SLTU), an OP funct7 other than 0000000/0100000, a shift-immediate funct7 other than 0000000 (or 0100000 for SRAI), or any other opcode.
  - These are still issued, with ILLEGAL=1, RD_WE=0, SELECT=0, DATA1=0, DATA2=0, ROTATE=0.
- Destination: RD_ADDR=INSTR[11:7]. RD_WE=1 for legal instructions with RD_ADDR≠0, otherwise 0.
- For non-shift ops ROTATE=0.

Test Plan:
- Reset mid-stream (RESET_N low while OUT_VALID=1 and S full) -> all outputs 0 and IN_READY=1 immediately; after release, the first accepted instruction appears one cycle later.
- SUB x3,x1,x2 with RS1=5, RS2=7, OUT_READY=1 -> next cycle SELECT=1, DATA1=5, DATA2=0xFFFFFFF9, RD_ADDR=3, RD_WE=1.
- SRAI x4,x4,31 with RS1=0x80000000, then SRA with RS2=0xFFFFFFE3 -> first: SELECT=6, ROTATE=1, DATA2=31; second: DATA2=3.
- Back-to-back stream of 4 ADDIs with OUT_READY held 0 for 3 cycles -> IN_READY falls after 2 accepts; order preserved; no loss or duplication; all 4 drain at one per cycle once OUT_READY=1.
- FLUSH asserted with O and S full and IN_VALID=1 -> next cycle OUT_VALID=0, IN_READY=1; the offered instruction is never issued.
- SLT and opcode 0000011 (load) -> ILLEGAL=1, RD_WE=0, SELECT=0, DATA1=0, DATA2=0. LUI x0 -> RD_WE=0, ILLEGAL=0.
